// File: rtl/trace_logger_ring_pkg.sv
// Shared types and default sizes for the trace logger ring.
package trace_logger_ring_pkg;

    localparam int LOGGER_WIDTH      = 64;
    localparam int LOGGER_DEPTH      = 64;
    localparam int LOGGER_DELAY_BITS = 8;
    localparam int LOGGER_OVF_BITS   = 16;

    typedef enum logic {
        MODE_STREAM  = 1'b0,
        MODE_CAPTURE = 1'b1
    } logger_mode_t;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_DELAY  = 2'd1,
        ST_FROZEN = 2'd2
    } logger_state_t;

    typedef struct packed {
        logic empty;
        logic full;
        logic triggered;
        logic frozen;
        logic trg_delayed;
    } logger_stat_t;

endpackage

// File: rtl/trace_ring_ptr.sv
// Wrapping write/read pointers and occupancy count for the trace ring.
module trace_ring_ptr #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr,
    input  logic          rd,
    input  logic          overwrite,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic adv_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A write into a full overwriting ring drops the oldest word, so count holds.
    assign adv_rd = rd | (wr & overwrite & full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(adv_rd);
            count  <= count + (AW+1)'(wr) - (AW+1)'(adv_rd);
        end
    end

endmodule

// File: rtl/trace_logger_ring.sv
// Trace buffer controller: STREAM FIFO or CAPTURE ring with trigger/delay/freeze.
// DTB_LOGGER_OVF_CNT_EN builds the dropped-store counter; otherwise OVF_CNT_O is 0.
import trace_logger_ring_pkg::*;

module trace_logger_ring #(
    parameter  int WIDTH      = LOGGER_WIDTH,
    parameter  int DEPTH      = LOGGER_DEPTH,
    parameter  int DELAY_BITS = LOGGER_DELAY_BITS,
    parameter  int OVF_BITS   = LOGGER_OVF_BITS,
    localparam int AW         = $clog2(DEPTH),
    localparam int PW         = $clog2(WIDTH)
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic                  CLEAR_I,
    input  logic                  MODE_I,
    input  logic [DELAY_BITS-1:0] DELAY_I,
    input  logic [WIDTH-1:0]      DATA_I,
    input  logic                  STORE_I,
    output logic                  STORE_PERM_O,
    input  logic                  LOAD_REQUEST_I,
    output logic                  LOAD_GRANT_O,
    output logic [WIDTH-1:0]      DATA_O,
    output logic                  WRITE_O,
    output logic [AW-1:0]         WRITE_PTR_O,
    output logic [WIDTH-1:0]      DMEM_O,
    output logic [AW-1:0]         READ_PTR_O,
    input  logic [WIDTH-1:0]      DMEM_I,
    input  logic                  TRG_EVENT_I,
    input  logic [PW-1:0]         EVENT_POS_I,
    output logic [AW:0]           COUNT_O,
    output logic                  EMPTY_O,
    output logic                  FULL_O,
    output logic                  TRIGGERED_O,
    output logic                  FROZEN_O,
    output logic                  TRG_DELAYED_O,
    output logic [AW-1:0]         TRG_PTR_O,
    output logic [PW-1:0]         EVENT_POS_O,
    output logic [OVF_BITS-1:0]   OVF_CNT_O
);

    logger_mode_t          mode_q;
    logger_state_t         state, state_nxt;
    logger_stat_t          stat;
    logic [DELAY_BITS-1:0] delay_q, delay_cnt, delay_nxt;
    logic                  capture, write, load_ok, load_acc, trg_hit;
    logic                  triggered, trg_delayed, grant;
    logic [AW-1:0]         wr_ptr, rd_ptr, trg_ptr;
    logic [PW-1:0]         event_pos;
    logic [AW:0]           count;
    logic                  full, empty;

    assign capture = (mode_q == MODE_CAPTURE);

    always_comb begin
        STORE_PERM_O = capture ? (state != ST_FROZEN) : !full;
        load_ok      = capture ? (state == ST_FROZEN && !empty) : !empty;
    end

    assign write    = STORE_I & STORE_PERM_O;
    assign load_acc = LOAD_REQUEST_I & load_ok;
    // Only the first trigger is latched; in CAPTURE that is the ARMED one.
    assign trg_hit  = TRG_EVENT_I & !triggered & (!capture | (state == ST_ARMED));

    trace_ring_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk       (CLK_I),
        .rst_n     (RST_NI),
        .clear     (CLEAR_I),
        .wr        (write),
        .rd        (load_acc),
        .overwrite (capture),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_nxt = state;
        delay_nxt = delay_cnt;
        case (state)
            ST_ARMED: if (capture && trg_hit) begin
                delay_nxt = delay_q;
                state_nxt = (delay_q == '0) ? ST_FROZEN : ST_DELAY;
            end
            ST_DELAY: if (write) begin
                delay_nxt = delay_cnt - DELAY_BITS'(1);
                if (delay_cnt == DELAY_BITS'(1)) state_nxt = ST_FROZEN;
            end
            default: ;
        endcase
    end

    // Mode/delay shadows follow the inputs while reset or clear is applied.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            mode_q    <= logger_mode_t'(MODE_I);
            delay_q   <= DELAY_I;
            state     <= ST_ARMED;
            delay_cnt <= '0;
        end else if (CLEAR_I) begin
            mode_q    <= logger_mode_t'(MODE_I);
            delay_q   <= DELAY_I;
            state     <= ST_ARMED;
            delay_cnt <= '0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            grant       <= 1'b0;
            triggered   <= 1'b0;
            trg_delayed <= 1'b0;
            trg_ptr     <= '0;
            event_pos   <= '0;
        end else if (CLEAR_I) begin
            grant       <= 1'b0;
            triggered   <= 1'b0;
            trg_delayed <= 1'b0;
            trg_ptr     <= '0;
            event_pos   <= '0;
        end else begin
            grant       <= load_acc;
            trg_delayed <= (state_nxt == ST_FROZEN) && (state != ST_FROZEN);
            if (trg_hit) begin
                triggered <= 1'b1;
                trg_ptr   <= wr_ptr;
                event_pos <= EVENT_POS_I;
            end
        end
    end

`ifdef DTB_LOGGER_OVF_CNT_EN
    logic [OVF_BITS-1:0] ovf_cnt;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI)
            ovf_cnt <= '0;
        else if (CLEAR_I)
            ovf_cnt <= '0;
        else if (!capture && STORE_I && full && ovf_cnt != '1)
            ovf_cnt <= ovf_cnt + OVF_BITS'(1);
    end

    assign OVF_CNT_O = ovf_cnt;
`else
    assign OVF_CNT_O = '0;
`endif

    assign stat = '{empty: empty, full: full, triggered: triggered,
                    frozen: (state == ST_FROZEN), trg_delayed: trg_delayed};

    assign WRITE_O       = write;
    assign WRITE_PTR_O   = wr_ptr;
    assign DMEM_O        = DATA_I;
    assign READ_PTR_O    = rd_ptr;
    assign LOAD_GRANT_O  = grant;
    // Memory read data lands one cycle after the address, aligned with the grant.
    assign DATA_O        = grant ? DMEM_I : '0;
    assign COUNT_O       = count;
    assign EMPTY_O       = stat.empty;
    assign FULL_O        = stat.full;
    assign TRIGGERED_O   = stat.triggered;
    assign FROZEN_O      = stat.frozen;
    assign TRG_DELAYED_O = stat.trg_delayed;
    assign TRG_PTR_O     = trg_ptr;
    assign EVENT_POS_O   = event_pos;

endmodule

// File: tb/tb_trace_logger_ring.sv
// Directed scoreboard bench for trace_logger_ring (WIDTH=32, DEPTH=8, DELAY_BITS=4).
module tb_trace_logger_ring;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int DB = 4;
    localparam int OB = 16;
`ifdef DTB_LOGGER_OVF_CNT_EN
    localparam int OVF_EXP = 2;
`else
    localparam int OVF_EXP = 0;
`endif

    logic          CLK_I = 1'b0;
    logic          RST_NI = 1'b0;
    logic          CLEAR_I = 1'b0;
    logic          MODE_I = 1'b0;
    logic [DB-1:0] DELAY_I = '0;
    logic [W-1:0]  DATA_I = '0;
    logic          STORE_I = 1'b0;
    logic          LOAD_REQUEST_I = 1'b0;
    logic [W-1:0]  DMEM_I = '0;
    logic          TRG_EVENT_I = 1'b0;
    logic [4:0]    EVENT_POS_I = '0;
    logic          STORE_PERM_O, LOAD_GRANT_O, WRITE_O;
    logic [W-1:0]  DATA_O, DMEM_O;
    logic [2:0]    WRITE_PTR_O, READ_PTR_O, TRG_PTR_O;
    logic [3:0]    COUNT_O;
    logic          EMPTY_O, FULL_O, TRIGGERED_O, FROZEN_O, TRG_DELAYED_O;
    logic [4:0]    EVENT_POS_O;
    logic [OB-1:0] OVF_CNT_O;

    int           total = 0;
    int           bad = 0;
    int           wr_seen = 0;
    int           pulses = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_word;
    logic [W-1:0] mem[D];

    trace_logger_ring #(.WIDTH(W), .DEPTH(D), .DELAY_BITS(DB), .OVF_BITS(OB)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI), .CLEAR_I(CLEAR_I), .MODE_I(MODE_I),
        .DELAY_I(DELAY_I), .DATA_I(DATA_I), .STORE_I(STORE_I), .STORE_PERM_O(STORE_PERM_O),
        .LOAD_REQUEST_I(LOAD_REQUEST_I), .LOAD_GRANT_O(LOAD_GRANT_O), .DATA_O(DATA_O),
        .WRITE_O(WRITE_O), .WRITE_PTR_O(WRITE_PTR_O), .DMEM_O(DMEM_O), .READ_PTR_O(READ_PTR_O),
        .DMEM_I(DMEM_I), .TRG_EVENT_I(TRG_EVENT_I), .EVENT_POS_I(EVENT_POS_I),
        .COUNT_O(COUNT_O), .EMPTY_O(EMPTY_O), .FULL_O(FULL_O), .TRIGGERED_O(TRIGGERED_O),
        .FROZEN_O(FROZEN_O), .TRG_DELAYED_O(TRG_DELAYED_O), .TRG_PTR_O(TRG_PTR_O),
        .EVENT_POS_O(EVENT_POS_O), .OVF_CNT_O(OVF_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    // External dual-port trace memory, one-cycle read latency.
    always @(posedge CLK_I) begin
        if (WRITE_O) mem[WRITE_PTR_O] <= DMEM_O;
        DMEM_I <= mem[READ_PTR_O];
    end

    // Monitor: every grant consumes one expected word.
    always @(negedge CLK_I) begin
        if (LOAD_GRANT_O) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL grant_unexpected got=%0d want=no_grant", DATA_O);
            end else begin
                exp_word = sb.pop_front();
                if (DATA_O !== exp_word) begin
                    bad++;
                    $display("FAIL load_data got=%0d want=%0d", DATA_O, exp_word);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic step(input logic st, input logic [W-1:0] d, input logic ld,
                        input logic trg, input logic clr);
        STORE_I = st; DATA_I = d; LOAD_REQUEST_I = ld; TRG_EVENT_I = trg; CLEAR_I = clr;
        @(negedge CLK_I);
        if (WRITE_O) wr_seen++;
        if (TRG_DELAYED_O) pulses++;
        @(posedge CLK_I);
        #1;
        STORE_I = 1'b0; LOAD_REQUEST_I = 1'b0; TRG_EVENT_I = 1'b0; CLEAR_I = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK_I);
        #1 RST_NI = 1'b1;
        chk("rst_count", COUNT_O, 0);
        chk("rst_empty", EMPTY_O, 1);
        chk("rst_full", FULL_O, 0);
        chk("rst_perm", STORE_PERM_O, 1);
        chk("rst_grant", LOAD_GRANT_O, 0);
        chk("rst_data", DATA_O, 0);
        chk("rst_trig", TRIGGERED_O, 0);
        chk("rst_ovf", OVF_CNT_O, 0);

        // STREAM fill past full, then drain
        wr_seen = 0;
        for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        chk("s_fill_writes", wr_seen, 8);
        chk("s_fill_full", FULL_O, 1);
        chk("s_fill_perm", STORE_PERM_O, 0);
        chk("s_fill_ovf", OVF_CNT_O, OVF_EXP);
        for (int i = 1; i <= 8; i++) begin
            sb.push_back(W'(i));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("s_drain_empty", EMPTY_O, 1);
        chk("s_drain_count", COUNT_O, 0);

        // STREAM steady state at COUNT_O=3 with store+load each cycle
        for (int i = 0; i < 3; i++) step(1'b1, W'(101 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            sb.push_back(W'(101 + k));
            step(1'b1, W'(104 + k), 1'b1, 1'b0, 1'b0);
            chk("s_steady_count", COUNT_O, 3);
        end
        chk("s_steady_wptr", WRITE_PTR_O, 7);
        chk("s_steady_rptr", READ_PTR_O, 4);
        for (int k = 0; k < 3; k++) begin
            sb.push_back(W'(121 + k));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("s_steady_empty", EMPTY_O, 1);

        // CAPTURE with delay 3, trigger on word 6
        MODE_I = 1'b1; DELAY_I = 4'd3;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("c3_clear_wptr", WRITE_PTR_O, 0);
        pulses = 0;
        EVENT_POS_I = 5'd17;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, W'(i), 1'b0, (i == 6), 1'b0);
            if (i == 8) chk("c3_not_frozen_w8", FROZEN_O, 0);
            if (i == 9) chk("c3_frozen_w9", FROZEN_O, 1);
        end
        chk("c3_trg_ptr", TRG_PTR_O, 5);
        chk("c3_event_pos", EVENT_POS_O, 17);
        chk("c3_triggered", TRIGGERED_O, 1);
        chk("c3_pulses", pulses, 1);
        chk("c3_count", COUNT_O, 8);
        chk("c3_perm", STORE_PERM_O, 0);
        for (int i = 2; i <= 9; i++) begin
            sb.push_back(W'(i));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("c3_drain_empty", EMPTY_O, 1);
        chk("c3_still_frozen", FROZEN_O, 1);

        // CAPTURE with delay 0, trigger on word 4
        DELAY_I = 4'd0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, (i == 4), 1'b0);
        chk("c0_frozen", FROZEN_O, 1);
        chk("c0_count", COUNT_O, 4);
        chk("c0_trg_ptr", TRG_PTR_O, 3);
        step(1'b1, W'(5), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'(6), 1'b0, 1'b0, 1'b0);
        chk("c0_ignored_count", COUNT_O, 4);
        chk("c0_ovf", OVF_CNT_O, 0);

        // CLEAR collides with trigger and store
        DELAY_I = 4'd2;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, W'(77), 1'b0, 1'b0, 1'b0);
        chk("clr_pre_count", COUNT_O, 1);
        EVENT_POS_I = 5'd9;
        step(1'b1, W'(88), 1'b0, 1'b1, 1'b1);
        chk("clr_count", COUNT_O, 0);
        chk("clr_triggered", TRIGGERED_O, 0);
        chk("clr_trg_ptr", TRG_PTR_O, 0);
        chk("clr_event_pos", EVENT_POS_O, 0);
        chk("clr_wptr", WRITE_PTR_O, 0);
        chk("clr_empty", EMPTY_O, 1);

        // Async reset in the middle of a FROZEN drain
        DELAY_I = 4'd0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, W'(10 + i), 1'b0, (i == 5), 1'b0);
        chk("rd_frozen", FROZEN_O, 1);
        chk("rd_count", COUNT_O, 5);
        sb.push_back(W'(11));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        sb.push_back(W'(12));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("rd_grant_live", LOAD_GRANT_O, 1);
        LOAD_REQUEST_I = 1'b1;
        RST_NI = 1'b0;
        #1;
        chk("rd_rst_grant", LOAD_GRANT_O, 0);
        chk("rd_rst_data", DATA_O, 0);
        chk("rd_rst_count", COUNT_O, 0);
        chk("rd_rst_frozen", FROZEN_O, 0);
        chk("rd_rst_perm", STORE_PERM_O, 1);
        sb.delete();
        @(posedge CLK_I);
        #1 RST_NI = 1'b1;
        LOAD_REQUEST_I = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rd_after_grant", LOAD_GRANT_O, 0);
        chk("rd_after_trig", TRIGGERED_O, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
